// File: rtl/autoconfig_host.sv
// Zorro II AutoConfig initiator: walks the $E8xxxx config space and assigns bases.
// Optional ID capture (product/manufacturer) is built when AUTOCONFIG_HOST_IDCAP_EN is defined.
module autoconfig_host #(
  parameter int         MAX_BOARDS     = 8,
  parameter int         TIMEOUT_CYCLES = 64,
  parameter logic [7:0] FAST_BASE      = 8'h20,
  parameter logic [7:0] FAST_LIMIT     = 8'hA0,
  parameter logic [7:0] IO_BASE        = 8'hE9,
  parameter logic [7:0] IO_LIMIT       = 8'hEF
) (
  input  logic        MB_CLK,
  input  logic        RESET,
  input  logic        START,
  output logic [22:0] ADDRESS,
  input  logic [15:0] DATA_IN,
  output logic [15:0] DATA_OUT,
  output logic        DATA_OE,
  output logic        AS,
  output logic        UDS,
  output logic        LDS,
  output logic        RW,
  input  logic        DTACK,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  output logic [3:0]  BOARD_COUNT,
  output logic [7:0]  LAST_BASE
`ifdef AUTOCONFIG_HOST_IDCAP_EN
  ,
  output logic [15:0] MFG_ID,
  output logic [7:0]  PRODUCT_ID
`endif
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_TYPE_HI = 4'd1;
  localparam logic [3:0] S_TYPE_LO = 4'd2;
`ifdef AUTOCONFIG_HOST_IDCAP_EN
  localparam logic [3:0] S_ID      = 4'd3;
`endif
  localparam logic [3:0] S_ALLOC   = 4'd4;
  localparam logic [3:0] S_WR_LO   = 4'd5;
  localparam logic [3:0] S_WR_HI   = 4'd6;
  localparam logic [3:0] S_SHUTUP  = 4'd7;
  localparam logic [3:0] S_NEXT    = 4'd8;

  localparam logic [2:0] B_LOAD = 3'd0;
  localparam logic [2:0] B_ADDR = 3'd1;
  localparam logic [2:0] B_STRB = 3'd2;
  localparam logic [2:0] B_END  = 3'd3;
  localparam logic [2:0] B_REL  = 3'd4;

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [3:0]      st;
  logic [2:0]      bst;
  logic [TO_W-1:0] to_cnt;
  logic            dtack_p0, dtack_p1;
  logic            dtack_s;
  logic [7:0]      fast_ptr, io_ptr;
  logic [3:0]      nib_q, typ_hi_q, typ_lo_q;
  logic [7:0]      base_q;
`ifdef AUTOCONFIG_HOST_IDCAP_EN
  logic [2:0]      id_idx;
`endif

  logic [7:0]      ld_off;
  logic            ld_wr;
  logic [3:0]      ld_nib;
  logic [2:0]      size_code;
  logic [8:0]      alloc_size, alloc_base, alloc_end;
  logic            in_fast, fits;
  logic [7:0]      pool_ptr, pool_base, pool_lim;
  logic            cyc_done;

  function automatic logic [7:0] reg_offset(input logic [3:0] s);
    logic [7:0] off;
    off = 8'h00;
    case (s)
      S_TYPE_LO: off = 8'h02;
      S_WR_LO:   off = 8'h4A;
      S_WR_HI:   off = 8'h48;
      S_SHUTUP:  off = 8'h4C;
      default:   off = 8'h00;
    endcase
    return off;
  endfunction

`ifdef AUTOCONFIG_HOST_IDCAP_EN
  function automatic logic [7:0] id_offset(input logic [2:0] idx);
    logic [7:0] off;
    case (idx)
      3'd0:    off = 8'h04;
      3'd1:    off = 8'h06;
      3'd2:    off = 8'h10;
      3'd3:    off = 8'h12;
      3'd4:    off = 8'h14;
      default: off = 8'h16;
    endcase
    return off;
  endfunction
`endif

  function automatic logic [8:0] align_up(input logic [8:0] off, input logic [8:0] size);
    return (off + size - 9'd1) & ~(size - 9'd1);
  endfunction

  assign LDS     = 1'b1;
  assign dtack_s = dtack_p1;
  assign cyc_done = (bst == B_REL) && dtack_s;

  // DTACK synchroniser, two stages
  always_ff @(posedge MB_CLK or posedge RESET) begin
    if (RESET) begin
      dtack_p0 <= 1'b1;
      dtack_p1 <= 1'b1;
    end else begin
      dtack_p0 <= DTACK;
      dtack_p1 <= dtack_p0;
    end
  end

  always_comb begin
`ifdef AUTOCONFIG_HOST_IDCAP_EN
    ld_off = (st == S_ID) ? id_offset(id_idx) : reg_offset(st);
`else
    ld_off = reg_offset(st);
`endif
    ld_wr  = (st == S_WR_LO) || (st == S_WR_HI) || (st == S_SHUTUP);
    ld_nib = (st == S_WR_LO) ? base_q[3:0] : (st == S_WR_HI) ? base_q[7:4] : 4'h0;
  end

  // Alignment is measured from the pool start, so a 4MB board may sit at $20.
  always_comb begin
    size_code  = typ_lo_q[2:0];
    alloc_size = (size_code == 3'd0) ? 9'd0 : (9'd1 << (size_code - 3'd1));
    in_fast    = typ_hi_q[1];
    pool_ptr   = in_fast ? fast_ptr   : io_ptr;
    pool_base  = in_fast ? FAST_BASE  : IO_BASE;
    pool_lim   = in_fast ? FAST_LIMIT : IO_LIMIT;
    alloc_base = align_up({1'b0, pool_ptr} - {1'b0, pool_base}, alloc_size) + {1'b0, pool_base};
    alloc_end  = alloc_base + alloc_size;
    fits       = (size_code != 3'd0) && (alloc_end <= {1'b0, pool_lim});
  end

  always_ff @(posedge MB_CLK) begin
    if ((bst == B_STRB) && !dtack_s) nib_q <= DATA_IN[15:12];
    if (cyc_done && (st == S_TYPE_HI)) typ_hi_q <= nib_q;
    if (cyc_done && (st == S_TYPE_LO)) typ_lo_q <= nib_q;
    if ((st == S_ALLOC) && fits) base_q <= alloc_base[7:0];
  end

  always_ff @(posedge MB_CLK or posedge RESET) begin
    if (RESET) begin
      st          <= S_IDLE;
      bst         <= B_LOAD;
      to_cnt      <= '0;
      ADDRESS     <= '0;
      DATA_OUT    <= '0;
      DATA_OE     <= 1'b0;
      AS          <= 1'b1;
      UDS         <= 1'b1;
      RW          <= 1'b1;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      ERROR       <= 1'b0;
      BOARD_COUNT <= '0;
      LAST_BASE   <= '0;
      fast_ptr    <= '0;
      io_ptr      <= '0;
`ifdef AUTOCONFIG_HOST_IDCAP_EN
      id_idx      <= '0;
      MFG_ID      <= '0;
      PRODUCT_ID  <= '0;
`endif
    end else begin
      case (st)
        S_IDLE: begin
          if (START) begin
            BUSY        <= 1'b1;
            DONE        <= 1'b0;
            ERROR       <= 1'b0;
            BOARD_COUNT <= '0;
            LAST_BASE   <= '0;
            fast_ptr    <= FAST_BASE;
            io_ptr      <= IO_BASE;
            st          <= S_TYPE_HI;
            bst         <= B_LOAD;
          end
        end
        S_ALLOC: begin
          if (fits) begin
            if (in_fast) fast_ptr <= alloc_end[7:0];
            else         io_ptr   <= alloc_end[7:0];
            st <= S_WR_LO;
          end else begin
            st <= S_SHUTUP;
          end
          bst <= B_LOAD;
        end
        S_NEXT: begin
          if (BOARD_COUNT == 4'(MAX_BOARDS)) begin
            st   <= S_IDLE;
            BUSY <= 1'b0;
            DONE <= 1'b1;
          end else begin
            st  <= S_TYPE_HI;
            bst <= B_LOAD;
          end
        end
        default: begin
          case (bst)
            B_LOAD: begin
              ADDRESS  <= {8'hE8, 8'h00, ld_off[7:1]};
              RW       <= ~ld_wr;
              DATA_OE  <= ld_wr;
              DATA_OUT <= {ld_nib, 12'h000};
              bst      <= B_ADDR;
            end
            B_ADDR: begin
              AS     <= 1'b0;
              UDS    <= 1'b0;
              to_cnt <= '0;
              bst    <= B_STRB;
            end
            B_STRB: begin
              if (!dtack_s) begin
                AS      <= 1'b1;
                UDS     <= 1'b1;
                DATA_OE <= 1'b0;
                bst     <= B_END;
              end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                // No answer on $00 just means the bus is empty.
                AS      <= 1'b1;
                UDS     <= 1'b1;
                DATA_OE <= 1'b0;
                st      <= S_IDLE;
                bst     <= B_LOAD;
                BUSY    <= 1'b0;
                DONE    <= 1'b1;
                ERROR   <= (st != S_TYPE_HI);
              end else begin
                to_cnt <= to_cnt + 1'b1;
              end
            end
            B_END: bst <= B_REL;
            default: begin
              if (dtack_s) begin
                bst <= B_LOAD;
                case (st)
                  S_TYPE_HI: st <= S_TYPE_LO;
                  S_TYPE_LO: begin
                    if (typ_hi_q[3:2] != 2'b11) begin
                      st   <= S_IDLE;
                      BUSY <= 1'b0;
                      DONE <= 1'b1;
                    end else begin
`ifdef AUTOCONFIG_HOST_IDCAP_EN
                      id_idx <= '0;
                      st     <= S_ID;
`else
                      st     <= S_ALLOC;
`endif
                    end
                  end
`ifdef AUTOCONFIG_HOST_IDCAP_EN
                  S_ID: begin
                    if (id_idx < 3'd2) PRODUCT_ID <= {PRODUCT_ID[3:0], ~nib_q};
                    else               MFG_ID     <= {MFG_ID[11:0], ~nib_q};
                    if (id_idx == 3'd5) st <= S_ALLOC;
                    else                id_idx <= id_idx + 3'd1;
                  end
`endif
                  S_WR_LO: st <= S_WR_HI;
                  S_WR_HI: begin
                    BOARD_COUNT <= BOARD_COUNT + 4'd1;
                    LAST_BASE   <= base_q;
                    st          <= S_NEXT;
                  end
                  S_SHUTUP: begin
                    BOARD_COUNT <= BOARD_COUNT + 4'd1;
                    LAST_BASE   <= 8'h00;
                    st          <= S_NEXT;
                  end
                  default: st <= S_IDLE;
                endcase
              end
            end
          endcase
        end
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{DATA_IN[11:0], ld_off[0], typ_hi_q[0], typ_lo_q[3], alloc_base[8]};

endmodule

// File: tb/tb_autoconfig_host.sv
// Bench for autoconfig_host: a card-side responder chain plus a write scoreboard.
module tb_autoconfig_host;

  logic        MB_CLK = 1'b0;
  logic        RESET, START, DTACK;
  logic [22:0] ADDRESS;
  logic [15:0] DATA_IN, DATA_OUT;
  logic        DATA_OE, AS, UDS, LDS, RW;
  logic        BUSY, DONE, ERROR;
  logic [3:0]  BOARD_COUNT;
  logic [7:0]  LAST_BASE;
`ifdef AUTOCONFIG_HOST_IDCAP_EN
  logic [15:0] MFG_ID;
  logic [7:0]  PRODUCT_ID;
`endif

  autoconfig_host dut (
    .MB_CLK(MB_CLK), .RESET(RESET), .START(START), .ADDRESS(ADDRESS),
    .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE),
    .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW), .DTACK(DTACK),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
    .BOARD_COUNT(BOARD_COUNT), .LAST_BASE(LAST_BASE)
`ifdef AUTOCONFIG_HOST_IDCAP_EN
    , .MFG_ID(MFG_ID), .PRODUCT_ID(PRODUCT_ID)
`endif
  );

  always #5 MB_CLK = ~MB_CLK;

  typedef struct packed {
    logic [7:0] off;
    logic [3:0] nib;
  } wr_t;

  wr_t        exp_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] brd_type [0:7];
  logic [7:0] brd_prod = 8'd0;
  logic [15:0] brd_mfg = 16'h0;
  int         nbrd = 0;
  int         cur = 0;
  bit         stall02 = 1'b0;
  int         as_low_len = 0;
  int         last_as_low = 0;
  bit         acked = 1'b0;
  int         wait_cnt = 0;
  bit         wr_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] off, input logic [3:0] nib);
    wr_t w;
    w.off = off;
    w.nib = nib;
    exp_q.push_back(w);
  endtask

  function automatic logic [3:0] rd_nib(input logic [7:0] off, input logic [7:0] t);
    logic [3:0] n;
    case (off)
      8'h00:   n = t[7:4];
      8'h02:   n = t[3:0];
      8'h04:   n = ~brd_prod[7:4];
      8'h06:   n = ~brd_prod[3:0];
      8'h10:   n = ~brd_mfg[15:12];
      8'h12:   n = ~brd_mfg[11:8];
      8'h14:   n = ~brd_mfg[7:4];
      8'h16:   n = ~brd_mfg[3:0];
      default: n = 4'h0;
    endcase
    return n;
  endfunction

  // Card chain: only the first unconfigured board answers; $48 or $4C moves on.
  always @(negedge MB_CLK) begin
    logic [7:0] off;
    off = {ADDRESS[6:0], 1'b0};
    if (RESET || AS) begin
      if (as_low_len != 0) last_as_low = as_low_len;
      as_low_len = 0;
      DTACK = 1'b1;
      acked = 1'b0;
      wait_cnt = 0;
    end else begin
      as_low_len++;
      if (!acked) begin
        wait_cnt++;
        if (wait_cnt == 2 && cur < nbrd && !(stall02 && off == 8'h02)) begin
          acked = 1'b1;
          DTACK = 1'b0;
          if (RW) DATA_IN = {rd_nib(off, brd_type[cur]), 12'h000};
          else if (off == 8'h48 || off == 8'h4C) cur++;
        end
      end
    end
  end

  // Write monitor: every write strobe is matched against the expected queue.
  always @(negedge MB_CLK) begin
    wr_t e;
    if (AS) begin
      wr_seen = 1'b0;
    end else if (!RW && !wr_seen) begin
      wr_seen = 1'b1;
      if (exp_q.size() == 0) begin
        check("wr_unexpected_addr", {9'h0, ADDRESS}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {9'h0, ADDRESS}, {9'h0, 8'hE8, 8'h00, e.off[7:1]});
        check("wr_data", {16'h0, DATA_OUT}, {16'h0, e.nib, 12'h000});
        check("wr_oe", {31'h0, DATA_OE}, 32'd1);
      end
    end
  end

  task automatic run_scan(input int budget);
    bit seen;
    START = 1'b1;
    @(negedge MB_CLK);
    START = 1'b0;
    check("busy_after_start", {31'h0, BUSY}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge MB_CLK);
      if (DONE) seen = 1'b1;
    end
    @(negedge MB_CLK);
    check("done", {31'h0, DONE}, 32'd1);
  endtask

  task automatic end_checks(input logic [3:0] cnt, input logic [7:0] last, input logic err);
    check("board_count", {28'h0, BOARD_COUNT}, {28'h0, cnt});
    check("last_base", {24'h0, LAST_BASE}, {24'h0, last});
    check("error", {31'h0, ERROR}, {31'h0, err});
    check("busy_end", {31'h0, BUSY}, 32'd0);
    check("writes_left", exp_q.size(), 32'd0);
  endtask

  task automatic new_bus(input int n);
    cur = 0;
    nbrd = n;
    stall02 = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    bit seen;
    RESET = 1'b1;
    START = 1'b0;
    DTACK = 1'b1;
    DATA_IN = 16'h0;
    repeat (3) @(negedge MB_CLK);
    #1;
    check("rst_as", {31'h0, AS}, 32'd1);
    check("rst_uds", {31'h0, UDS}, 32'd1);
    check("rst_lds", {31'h0, LDS}, 32'd1);
    check("rst_rw", {31'h0, RW}, 32'd1);
    check("rst_oe", {31'h0, DATA_OE}, 32'd0);
    check("rst_addr", {9'h0, ADDRESS}, 32'd0);
    check("rst_busy", {31'h0, BUSY}, 32'd0);
    check("rst_done", {31'h0, DONE}, 32'd0);
    check("rst_error", {31'h0, ERROR}, 32'd0);
    check("rst_count", {28'h0, BOARD_COUNT}, 32'd0);
    check("rst_last", {24'h0, LAST_BASE}, 32'd0);
    @(negedge MB_CLK);
    RESET = 1'b0;
    repeat (2) @(negedge MB_CLK);

    // 2MB fast board then two 64K I/O boards
    new_bus(3);
    brd_type[0] = 8'hE6; brd_type[1] = 8'hC1; brd_type[2] = 8'hC1;
    push(8'h4A, 4'h0); push(8'h48, 4'h2);
    push(8'h4A, 4'h9); push(8'h48, 4'hE);
    push(8'h4A, 4'hA); push(8'h48, 4'hE);
    run_scan(3000);
    end_checks(4'd3, 8'hEA, 1'b0);

    // Alignment: 1MB, 2MB, then 1MB lands on the final fast pointer $60
    new_bus(3);
    brd_type[0] = 8'hE5; brd_type[1] = 8'hE6; brd_type[2] = 8'hE5;
    push(8'h4A, 4'h0); push(8'h48, 4'h2);
    push(8'h4A, 4'h0); push(8'h48, 4'h4);
    push(8'h4A, 4'h0); push(8'h48, 4'h6);
    run_scan(3000);
    end_checks(4'd3, 8'h60, 1'b0);

    // Exhaustion: five 4MB boards, last three shut up
    new_bus(5);
    for (int i = 0; i < 5; i++) brd_type[i] = 8'hE7;
    push(8'h4A, 4'h0); push(8'h48, 4'h2);
    push(8'h4A, 4'h0); push(8'h48, 4'h6);
    push(8'h4C, 4'h0); push(8'h4C, 4'h0); push(8'h4C, 4'h0);
    run_scan(4000);
    end_checks(4'd5, 8'h00, 1'b0);

    // 8MB size code shuts up; a bad type byte ends the scan cleanly
    new_bus(2);
    brd_type[0] = 8'hE0; brd_type[1] = 8'h06;
    push(8'h4C, 4'h0);
    run_scan(3000);
    end_checks(4'd1, 8'h00, 1'b0);

    // Mid-board timeout on $02
    new_bus(1);
    brd_type[0] = 8'hE6;
    stall02 = 1'b1;
    run_scan(3000);
    end_checks(4'd0, 8'h00, 1'b1);
    check("timeout_as_low_cycles", last_as_low, 32'd64);

    // Asynchronous reset while strobes are asserted
    new_bus(1);
    brd_type[0] = 8'hE6;
    START = 1'b1;
    @(negedge MB_CLK);
    START = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge MB_CLK);
      if (!AS) seen = 1'b1;
    end
    check("strobe_seen_before_reset", {31'h0, seen}, 32'd1);
    #2 RESET = 1'b1;
    #1;
    check("async_rst_as", {31'h0, AS}, 32'd1);
    check("async_rst_uds", {31'h0, UDS}, 32'd1);
    check("async_rst_busy", {31'h0, BUSY}, 32'd0);
    check("async_rst_oe", {31'h0, DATA_OE}, 32'd0);
    @(negedge MB_CLK);
    RESET = 1'b0;
    repeat (2) @(negedge MB_CLK);
    new_bus(1);
    brd_type[0] = 8'hE6;
    push(8'h4A, 4'h0); push(8'h48, 4'h2);
    run_scan(3000);
    end_checks(4'd1, 8'h20, 1'b0);

`ifdef AUTOCONFIG_HOST_IDCAP_EN
    new_bus(1);
    brd_type[0] = 8'hE6;
    brd_prod = 8'd103;
    brd_mfg = 16'h07B9;
    push(8'h4A, 4'h0); push(8'h48, 4'h2);
    run_scan(3000);
    end_checks(4'd1, 8'h20, 1'b0);
    check("product_id", {24'h0, PRODUCT_ID}, 32'd103);
    check("mfg_id", {16'h0, MFG_ID}, 32'h0000_07B9);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
